// File: rtl/bus_slave_resp_if.sv
// Request/response bus between one granted master and bus_slave_resp.
// Signals:
//   s_sel  - request strobe from the granted master
//   s_wr   - 1 = write, 0 = read, qualified by s_sel
//   s_addr - word address
//   s_din  - write data
//   s_ack  - one-cycle response strobe
//   s_err  - address error, valid with s_ack
//   s_dout - read data
interface bus_slave_resp_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic              s_ack;
  logic              s_err;
  logic [DATA_W-1:0] s_dout;

  modport master (
    output s_sel, s_wr, s_addr, s_din,
    input  s_ack, s_err, s_dout
  );

  modport slave (
    input  s_sel, s_wr, s_addr, s_din,
    output s_ack, s_err, s_dout
  );
endinterface

// File: rtl/bus_slave_resp.sv
// Bus slave with a small word memory and a fixed number of wait states
// before each single-cycle response.
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset, clears state, outputs and memory
//   bus     - slave side of bus_slave_resp_if (s_sel/s_wr/s_addr/s_din in,
//             s_ack/s_err/s_dout out, all outputs registered)
module bus_slave_resp #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  bus_slave_resp_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Extra top bit keeps the range check correct when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ack, ack_n;
  logic              err, err_n;
  logic [DATA_W-1:0] dout, dout_n;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;
  logic              cap;
  logic              mem_we;
  logic              addr_ok;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [DEPTH];

  assign bus.s_ack  = ack;
  assign bus.s_err  = err;
  assign bus.s_dout = dout;

  // Range check and read port work only on the request captured at acceptance.
  assign addr_ok = {1'b0, lat_addr} < DEPTH_LIM;
  assign rd_data = mem[lat_addr[IDX_W-1:0]];

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ack_n   = ack;
    err_n   = err;
    dout_n  = dout;
    cap     = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.s_sel) begin
          cap     = 1'b1;
          cnt_n   = CNT_W'(WAIT_CYCLES);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          ack_n   = 1'b1;
          state_n = ACK;
          if (!addr_ok) begin
            // Errored accesses discard writes and zero the read data.
            err_n  = 1'b1;
            dout_n = '0;
          end else if (lat_wr) begin
            mem_we = 1'b1;
          end else begin
            dout_n = rd_data;
          end
        end
      end
      ACK: begin
        ack_n   = 1'b0;
        err_n   = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, output, request-capture and memory registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      dout     <= '0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ack   <= ack_n;
      err   <= err_n;
      dout  <= dout_n;
      if (cap) begin
        lat_wr   <= bus.s_wr;
        lat_addr <= bus.s_addr;
        lat_din  <= bus.s_din;
      end
      if (mem_we) begin
        mem[lat_addr[IDX_W-1:0]] <= lat_din;
      end
    end
  end

endmodule

// File: tb/tb_bus_slave_resp.sv
// Directed bench for bus_slave_resp: dut0 runs with 2 wait states and is
// checked through a response scoreboard; dut1 runs with 0 wait states.
module tb_bus_slave_resp;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] dout;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [31:0] mem_m [16];
  logic [31:0] dout_m;

  bus_slave_resp_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
  bus_slave_resp_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

  bus_slave_resp #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  bus_slave_resp #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one accepted request on dut0 (2 wait states).
  task automatic model_push(input logic wr, input logic [7:0] addr, input logic [31:0] din,
                            input int e0);
    exp_t x;
    x.cyc = e0 + 3;
    x.err = 1'b0;
    if (addr >= 8'd16) begin
      x.err  = 1'b1;
      dout_m = 32'h0;
    end else if (wr) begin
      mem_m[addr[3:0]] = din;
    end else begin
      dout_m = mem_m[addr[3:0]];
    end
    x.dout = dout_m;
    sbq.push_back(x);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    dout_m = 32'h0;
  endtask

  // One request on dut0; bus is scrambled after acceptance.
  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [31:0] din);
    @(negedge clk);
    bus0.s_sel  = 1'b1;
    bus0.s_wr   = wr;
    bus0.s_addr = addr;
    bus0.s_din  = din;
    @(posedge clk);
    #1;
    model_push(wr, addr, din, cyc);
    @(negedge clk);
    bus0.s_sel  = 1'b0;
    bus0.s_wr   = ~wr;
    bus0.s_addr = 8'hFF;
    bus0.s_din  = 32'h0BAD_0BAD;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 32'(sbq.size()), 32'h0);
      sbq.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  // One request on dut1 (0 wait states) with cycle-exact checks.
  task automatic v6_req(input logic wr, input logic [7:0] addr, input logic [31:0] din,
                        input logic exp_err, input logic [31:0] exp_dout);
    @(negedge clk);
    bus1.s_sel  = 1'b1;
    bus1.s_wr   = wr;
    bus1.s_addr = addr;
    bus1.s_din  = din;
    @(posedge clk);
    #1;
    check("v6_ack_e0", 32'(bus1.s_ack), 32'h0);
    @(negedge clk);
    bus1.s_sel  = 1'b0;
    bus1.s_addr = 8'hEE;
    @(posedge clk);
    #1;
    check("v6_ack_e1", 32'(bus1.s_ack), 32'h1);
    check("v6_err_e1", 32'(bus1.s_err), 32'(exp_err));
    check("v6_dout_e1", bus1.s_dout, exp_dout);
    @(posedge clk);
    #1;
    check("v6_ack_e2", 32'(bus1.s_ack), 32'h0);
    check("v6_err_e2", 32'(bus1.s_err), 32'h0);
  endtask

  // Response monitor for dut0.
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (bus0.s_ack === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_ack", 32'(bus0.s_ack), 32'h0);
        end else begin
          mon_e = sbq.pop_front();
          check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("ack_err", 32'(bus0.s_err), 32'(mon_e.err));
          check("ack_dout", bus0.s_dout, mon_e.dout);
        end
      end else begin
        check("idle_err", 32'(bus0.s_err), 32'h0);
        if (sbq.size() == 0) begin
          check("idle_ack", 32'(bus0.s_ack), 32'h0);
        end else if (cyc >= sbq[0].cyc) begin
          check("ack_missing", 32'(bus0.s_ack), 32'h1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    bus0.s_sel = 1'b0; bus0.s_wr = 1'b0; bus0.s_addr = '0; bus0.s_din = '0;
    bus1.s_sel = 1'b0; bus1.s_wr = 1'b0; bus1.s_addr = '0; bus1.s_din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus0.s_ack), 32'h0);
    check("rst_err", 32'(bus0.s_err), 32'h0);
    check("rst_dout", bus0.s_dout, 32'h0);
    check("rst_dout1", bus1.s_dout, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // V1/V2: write then read back
    do_req(1'b1, 8'd3, 32'hDEADBEEF); drain();
    do_req(1'b0, 8'd3, 32'h0);        drain();

    // V3: out-of-range read and write, then aliasing check on addr 4
    do_req(1'b0, 8'd20, 32'h0);       drain();
    do_req(1'b1, 8'd20, 32'h1);       drain();
    do_req(1'b0, 8'd4, 32'h0);        drain();

    // V4: s_sel held high with fresh values each cycle; accepted every 5 cycles
    @(negedge clk);
    for (int j = 0; j <= 10; j++) begin
      bus0.s_sel  = 1'b1;
      bus0.s_wr   = 1'b1;
      bus0.s_addr = 8'(j);
      bus0.s_din  = 32'h4000_0000 + 32'(j);
      @(posedge clk);
      #1;
      if (j % 5 == 0) model_push(1'b1, 8'(j), 32'h4000_0000 + 32'(j), cyc);
      @(negedge clk);
    end
    bus0.s_sel = 1'b0;
    drain();
    do_req(1'b0, 8'd0, 32'h0);  drain();
    do_req(1'b0, 8'd5, 32'h0);  drain();
    do_req(1'b0, 8'd10, 32'h0); drain();
    do_req(1'b0, 8'd1, 32'h0);  drain();
    do_req(1'b0, 8'd9, 32'h0);  drain();

    // V5: reset during WAIT aborts the write
    @(negedge clk);
    bus0.s_sel  = 1'b1;
    bus0.s_wr   = 1'b1;
    bus0.s_addr = 8'd5;
    bus0.s_din  = 32'h55;
    @(posedge clk);
    @(negedge clk);
    bus0.s_sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("v5_rst_ack", 32'(bus0.s_ack), 32'h0);
    check("v5_rst_dout", bus0.s_dout, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    do_req(1'b0, 8'd5, 32'h0); drain();
    do_req(1'b0, 8'd3, 32'h0); drain();

    // V6: zero wait states on dut1
    v6_req(1'b0, 8'd0, 32'h0, 1'b0, 32'h0);
    v6_req(1'b1, 8'd2, 32'hCAFEF00D, 1'b0, 32'h0);
    v6_req(1'b0, 8'd2, 32'h0, 1'b0, 32'hCAFEF00D);
    v6_req(1'b0, 8'd200, 32'h0, 1'b1, 32'h0);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
